// File: rtl/dll_lock_seq_if.sv
// dll_lock_seq_if: control/status bundle between the DLL lock sequencer
// and its phase detector / delay line / hold-control consumers.
interface dll_lock_seq_if #(
   parameter int CODE_W = 6
);
   logic              start;
   logic              pd_valid;
   logic              pd_up;
   logic [CODE_W-1:0] code;
   logic              m_sel;
   logic              div_m;
   logic              hold;
   logic              busy;
   logic              locked;

   modport master (
      output start, pd_valid, pd_up,
      input  code, m_sel, div_m, hold, busy, locked
   );

   modport slave (
      input  start, pd_valid, pd_up,
      output code, m_sel, div_m, hold, busy, locked
   );
endinterface

// File: rtl/dll_lock_seq.sv
// dll_lock_seq: FMDLL lock sequencer (SAR coarse, +/-1 fine, lock, drift).
// Build macro LOCK_FREEZE_EN freezes the delay code while LOCKED.
module dll_lock_seq #(
   parameter int CODE_W     = 6,
   parameter int SETTLE_CYC = 4,
   parameter int LOCK_CNT   = 8,
   parameter int CNT_W      = 4
) (
   input  logic          clk,
   input  logic          rst,
   dll_lock_seq_if.slave bus
);
   localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [CODE_W-1:0] CODE_MAX = '1;
   localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1) << (CODE_W - 1);
   localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(CODE_W - 1);
   localparam logic [CNT_W-1:0]  SET_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]  LOCK_N   = CNT_W'(LOCK_CNT);

   typedef enum logic [2:0] {
      IDLE, COARSE, SETTLE, FINE, LOCKED
   } state_e;

   state_e            state_q, state_d, ret_q, ret_d, tgt;
   logic [CODE_W-1:0] code_q, code_d, step_code;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  scnt_q, scnt_d;
   logic [CNT_W-1:0]  alt_q, alt_d, alt_n;
   logic [CNT_W-1:0]  run_q, run_d, run_n;
   logic              last_q, last_d, seen_q, seen_d;
   logic              m_sel_q, m_sel_d, div_m_q, div_m_d;
   logic              hold_q, hold_d, busy_q, busy_d;
   logic              locked_q, locked_d;
   logic              can_step;

   // A step against the end of the code range is a no-op and needs no settle.
   always_comb begin
      can_step  = bus.pd_up ? (code_q != CODE_MAX) : (code_q != '0);
      step_code = bus.pd_up ? code_q + 1'b1 : code_q - 1'b1;
      alt_n     = (seen_q && (bus.pd_up != last_q)) ? alt_q + 1'b1 : '0;
      run_n     = (bus.pd_up == last_q) ? run_q + 1'b1 : CNT_W'(1);
   end

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      tgt      = state_q;
      code_d   = code_q;
      idx_d    = idx_q;
      scnt_d   = scnt_q;
      alt_d    = alt_q;
      run_d    = run_q;
      last_d   = last_q;
      seen_d   = seen_q;
      m_sel_d  = m_sel_q;
      div_m_d  = div_m_q;
      hold_d   = hold_q;
      locked_d = locked_q;
      unique case (state_q)
         IDLE: if (bus.start) begin
            code_d  = CODE_MID;
            idx_d   = IDX_TOP;
            div_m_d = 1'b1;
            m_sel_d = 1'b0;
            ret_d   = COARSE;
            hold_d  = 1'b1;
            scnt_d  = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (scnt_q == SET_LAST) begin
               state_d = ret_q;
               hold_d  = 1'b0;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         COARSE: if (bus.pd_valid) begin
            if (!bus.pd_up) code_d[idx_q] = 1'b0;
            if (idx_q != '0) begin
               code_d[idx_q - 1'b1] = 1'b1;
               idx_d = idx_q - 1'b1;
               ret_d = COARSE;
            end else begin
               div_m_d = 1'b0;
               m_sel_d = 1'b1;
               ret_d   = FINE;
            end
            hold_d  = 1'b1;
            scnt_d  = '0;
            state_d = SETTLE;
         end
         FINE: if (bus.pd_valid) begin
            seen_d = 1'b1;
            last_d = bus.pd_up;
            if (alt_n == LOCK_N) begin
               alt_d    = '0;
               run_d    = '0;
               locked_d = 1'b1;
               tgt      = LOCKED;
            end else begin
               alt_d = alt_n;
               tgt   = FINE;
            end
            if (can_step) begin
               code_d  = step_code;
               hold_d  = 1'b1;
               scnt_d  = '0;
               ret_d   = tgt;
               state_d = SETTLE;
            end else begin
               state_d = tgt;
            end
         end
         LOCKED: if (bus.pd_valid) begin
            last_d = bus.pd_up;
            if (run_n == LOCK_N) begin
               run_d    = '0;
               alt_d    = '0;
               locked_d = 1'b0;
               tgt      = FINE;
            end else begin
               run_d = run_n;
               tgt   = LOCKED;
            end
`ifdef LOCK_FREEZE_EN
            state_d = tgt;
`else
            if (can_step) begin
               code_d  = step_code;
               hold_d  = 1'b1;
               scnt_d  = '0;
               ret_d   = tgt;
               state_d = SETTLE;
            end else begin
               state_d = tgt;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ret_q    <= IDLE;
         code_q   <= '0;
         idx_q    <= '0;
         scnt_q   <= '0;
         alt_q    <= '0;
         run_q    <= '0;
         last_q   <= 1'b0;
         seen_q   <= 1'b0;
         m_sel_q  <= 1'b0;
         div_m_q  <= 1'b0;
         hold_q   <= 1'b0;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         code_q   <= code_d;
         idx_q    <= idx_d;
         scnt_q   <= scnt_d;
         alt_q    <= alt_d;
         run_q    <= run_d;
         last_q   <= last_d;
         seen_q   <= seen_d;
         m_sel_q  <= m_sel_d;
         div_m_q  <= div_m_d;
         hold_q   <= hold_d;
         busy_q   <= busy_d;
         locked_q <= locked_d;
      end
   end

   assign bus.code   = code_q;
   assign bus.m_sel  = m_sel_q;
   assign bus.div_m  = div_m_q;
   assign bus.hold   = hold_q;
   assign bus.busy   = busy_q;
   assign bus.locked = locked_q;
endmodule

// File: tb/tb_dll_lock_seq.sv
// tb_dll_lock_seq: directed bench for dll_lock_seq with a decision-history
// reference model compared every cycle, plus literal checkpoints.
module tb_dll_lock_seq;
   localparam int CODE_W     = 6;
   localparam int SETTLE_CYC = 4;
   localparam int LOCK_CNT   = 8;
   localparam int CNT_W      = 4;
`ifdef LOCK_FREEZE_EN
   localparam bit FREEZE = 1'b1;
`else
   localparam bit FREEZE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   dll_lock_seq_if #(.CODE_W(CODE_W)) bus ();

   dll_lock_seq #(
      .CODE_W(CODE_W), .SETTLE_CYC(SETTLE_CYC),
      .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 coarse, 2 fine, 3 locked.
   int  md, mret, sleft, k, win, e_code;
   bit  e_msel, e_divm, e_hold, e_busy, e_lock;
   bit  dec[$];

   function automatic int trail_alt();
      int n = 0;
      for (int i = dec.size() - 1; i >= win && i >= 1; i--) begin
         if (dec[i] != dec[i-1]) n++;
         else break;
      end
      return n;
   endfunction

   function automatic int trail_run();
      int n = 0;
      for (int i = dec.size() - 1; i >= win; i--) begin
         if (dec[i] == dec[dec.size()-1]) n++;
         else break;
      end
      return n;
   endfunction

   task automatic settle(int r);
      sleft = SETTLE_CYC;
      e_hold = 1'b1;
      mret = r;
   endtask

   task automatic model_reset();
      md = 0; mret = 0; sleft = 0; k = 0; win = 0; e_code = 0;
      e_msel = 0; e_divm = 0; e_hold = 0; e_busy = 0; e_lock = 0;
      dec.delete();
   endtask

   task automatic model_step();
      int c, nxt;
      bit up, moved;
      up = bus.pd_up;
      if (sleft > 0) begin
         sleft--;
         if (sleft == 0) begin
            e_hold = 1'b0;
            md = mret;
         end
      end else if (md == 0) begin
         if (bus.start) begin
            e_code = 2 ** (CODE_W - 1);
            k = CODE_W - 1;
            e_divm = 1'b1;
            e_msel = 1'b0;
            e_busy = 1'b1;
            md = 1;
            settle(1);
         end
      end else if (md == 1) begin
         if (bus.pd_valid) begin
            c = e_code;
            if (!up) c -= 2 ** k;
            if (k > 0) begin
               c += 2 ** (k - 1);
               k--;
               settle(1);
            end else begin
               e_divm = 1'b0;
               e_msel = 1'b1;
               settle(2);
            end
            e_code = c;
         end
      end else if (bus.pd_valid) begin
         dec.push_back(up);
         c = e_code + (up ? 1 : -1);
         moved = (c >= 0) && (c <= 2 ** CODE_W - 1);
         if (md == 2) begin
            if (trail_alt() == LOCK_CNT) begin
               e_lock = 1'b1; nxt = 3; win = dec.size();
            end else nxt = 2;
         end else begin
            if (trail_run() == LOCK_CNT) begin
               e_lock = 1'b0; nxt = 2; win = dec.size();
            end else nxt = 3;
         end
         if (moved && !(FREEZE && md == 3)) begin
            e_code = c;
            settle(nxt);
         end else begin
            md = nxt;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      logic [CODE_W+4:0] act, exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            act = {bus.code, bus.m_sel, bus.div_m, bus.hold, bus.busy, bus.locked};
            exp = {CODE_W'(e_code), e_msel, e_divm, e_hold, e_busy, e_lock};
            checks++;
            if (act !== exp) begin
               failures++;
               $display("FAIL cycle_model t=%0t actual=%h required=%h (code,m_sel,div_m,hold,busy,locked)",
                        $time, act, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic lit(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic wait_hold(output int hc);
      hc = 0;
      while (bus.hold && hc < 50) begin
         hc++;
         @(negedge clk);
      end
      if (hc >= 50) lit("hold_bound", hc, SETTLE_CYC);
   endtask

   task automatic decide(bit up, output int hc);
      bus.pd_valid = 1'b1;
      bus.pd_up = up;
      @(negedge clk);
      bus.pd_valid = 1'b0;
      bus.pd_up = 1'b0;
      wait_hold(hc);
   endtask

   task automatic do_start();
      int hc;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_hold(hc);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      lit("rst_code", bus.code, 0);
      lit("rst_flags", {bus.m_sel, bus.div_m, bus.hold, bus.busy, bus.locked}, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int hc, n;
      int cexp[6] = '{48, 40, 36, 38, 37, 36};
      bus.start = 1'b0;
      bus.pd_valid = 1'b0;
      bus.pd_up = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      lit("reset_code", bus.code, 0);
      lit("reset_flags", {bus.m_sel, bus.div_m, bus.hold, bus.busy, bus.locked}, 0);

      // Abort a search at code 48 with reset.
      do_start();
      lit("start_code", bus.code, 32);
      decide(1'b1, hc);
      lit("coarse_first", bus.code, 48);
      pulse_rst();

      // Fresh search; pd_valid pulsed through the whole initial hold.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.hold && n < 50) begin
         bus.pd_valid = 1'b1;
         n++;
         @(negedge clk);
      end
      bus.pd_valid = 1'b0;
      lit("hold_ignore_len", n, SETTLE_CYC);
      lit("hold_ignore_code", bus.code, 32);

      for (int i = 0; i < 6; i++) begin
         decide(bus.code < 37, hc);
         lit($sformatf("coarse_%0d", i), bus.code, cexp[i]);
         if (i == 0) lit("hold_len", hc, SETTLE_CYC);
      end
      lit("fine_mode", {bus.m_sel, bus.div_m, bus.locked}, 3'b100);

      // start while busy must be ignored.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         decide(i % 2 == 0, hc);
         if (i == 7) lit("not_yet_locked", bus.locked, 0);
      end
      lit("locked", bus.locked, 1);
      lit("lock_code", bus.code, 37);

      for (int i = 0; i < 8; i++) begin
         decide(1'b0, hc);
         if (i == 6) lit("still_locked", bus.locked, 1);
      end
      lit("lock_lost", bus.locked, 0);
      lit("drift_code", bus.code, FREEZE ? 37 : 29);
      decide(1'b1, hc);
      lit("post_loss_code", bus.code, FREEZE ? 38 : 30);

      // Saturating search at the top of the range.
      pulse_rst();
      do_start();
      for (int i = 0; i < 6; i++) decide(1'b1, hc);
      lit("sat_coarse", bus.code, 63);
      for (int i = 0; i < 3; i++) begin
         decide(1'b1, hc);
         lit($sformatf("sat_hold_%0d", i), hc, 0);
      end
      lit("sat_code", bus.code, 63);
      lit("sat_unlocked", bus.locked, 0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
